// File: rtl/tc_gate_sweeper_pkg.sv
// Shared types and constants for the TC gate sweeper.
// Build option TC_SWEEP_STOP_ON_FAIL_EN is consumed by tc_gate_sweeper.
package tc_sweep_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DONE  = 2'd2
  } sweep_state_e;

  localparam int TC_SWEEP_MIN_HOLD = 2;

  function automatic int truth_width(input int in_width);
    return 1 << in_width;
  endfunction
endpackage

// File: rtl/tc_gate_sweeper_if.sv
// Host handshake plus gate-under-sweep signals for tc_gate_sweeper.
interface tc_gate_sweeper_if #(
  parameter int IN_WIDTH = 2
);
  logic                start;
  logic                gate_out;
  logic [IN_WIDTH-1:0] gate_in;
  logic                busy;
  logic                done;
  logic                pass;
  logic [IN_WIDTH:0]   err_count;
  logic [IN_WIDTH-1:0] first_fail;

  modport master (
    output start, gate_out,
    input  gate_in, busy, done, pass, err_count, first_fail
  );

  modport slave (
    input  start, gate_out,
    output gate_in, busy, done, pass, err_count, first_fail
  );
endinterface

// File: rtl/tc_gate_sweeper_hold_timer.sv
// Per-vector hold counter: counts 0..HOLD_CYCLES-1 while enabled, flags the last cycle.
module tc_hold_timer
  import tc_sweep_pkg::*;
#(
  parameter int HOLD_CYCLES = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic last
);
  // Holds shorter than the minimum leave no settle cycle, so clamp.
  localparam int HOLD_EFF = (HOLD_CYCLES < TC_SWEEP_MIN_HOLD) ? TC_SWEEP_MIN_HOLD : HOLD_CYCLES;
  localparam int HW       = $clog2(HOLD_EFF);
  localparam logic [HW-1:0] H_LAST = HW'(HOLD_EFF - 1);

  logic [HW-1:0] h;

  assign last = (h == H_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        h <= '0;
    else if (clear)  h <= '0;
    else if (enable) h <= last ? '0 : h + 1'b1;
  end
endmodule

// File: rtl/tc_gate_sweeper.sv
// Self-checking exhaustive sweep of a combinational gate against a truth table.
// Define TC_SWEEP_STOP_ON_FAIL_EN to end the sweep at the first mismatch.
module tc_gate_sweeper
  import tc_sweep_pkg::*;
#(
  parameter int IN_WIDTH    = 2,
  parameter int HOLD_CYCLES = 20,
  parameter logic [truth_width(IN_WIDTH)-1:0] TRUTH = 4'b1000
) (
  input logic              clk,
  input logic              rst,
  tc_gate_sweeper_if.slave bus
);
  localparam logic [1:0] IDLE  = ST_IDLE;
  localparam logic [1:0] DRIVE = ST_DRIVE;
  localparam logic [1:0] DONE  = ST_DONE;

  logic [1:0]          state;
  logic [IN_WIDTH-1:0] v;
  logic [IN_WIDTH:0]   err_count;
  logic [IN_WIDTH-1:0] first_fail;
  logic                pass;
  logic                last;
  logic                drive;
  logic                sample;
  logic                mism;
  logic                end_sweep;
  logic [IN_WIDTH:0]   err_nxt;

  assign drive  = (state == DRIVE);
  assign sample = drive && last;
  assign mism   = sample && (bus.gate_out != TRUTH[v]);
  assign err_nxt = err_count + (IN_WIDTH+1)'(mism);

`ifdef TC_SWEEP_STOP_ON_FAIL_EN
  assign end_sweep = sample && ((v == '1) || mism);
`else
  assign end_sweep = sample && (v == '1);
`endif

  tc_hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_hold (
    .clk    (clk),
    .rst    (rst),
    .clear  (!drive),
    .enable (drive),
    .last   (last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      v          <= '0;
      err_count  <= '0;
      first_fail <= '0;
      pass       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          state      <= DRIVE;
          v          <= '0;
          err_count  <= '0;
          first_fail <= '0;
          pass       <= 1'b0;
        end
        DRIVE: if (sample) begin
          err_count <= err_nxt;
          if (mism && err_count == '0) first_fail <= v;
          v <= v + 1'b1;
          if (end_sweep) begin
            state <= DONE;
            pass  <= (err_nxt == '0);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gate_in    = drive ? v : '0;
  assign bus.busy       = drive;
  assign bus.done       = (state == DONE);
  assign bus.pass       = pass;
  assign bus.err_count  = err_count;
  assign bus.first_fail = first_fail;
endmodule

// File: tb/tb_tc_gate_sweeper.sv
// Randomized self-checking bench for tc_gate_sweeper against a truth-table model.
module tb_tc_gate_sweeper;
  localparam int         W     = 2;
  localparam int         H     = 20;
  localparam int         NV    = 4;
  localparam logic [3:0] TRUTH = 4'b1000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  tc_gate_sweeper_if #(.IN_WIDTH(W)) bus();

  // Gate under sweep modelled as a lookup table indexed by the driven vector.
  logic [3:0] gate_tbl = 4'b1000;
  assign bus.gate_out = gate_tbl[bus.gate_in];

  tc_gate_sweeper #(.IN_WIDTH(W), .HOLD_CYCLES(H), .TRUTH(TRUTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".gate_in"},    32'(bus.gate_in),    0);
    chk({tag, ".busy"},       32'(bus.busy),       0);
    chk({tag, ".done"},       32'(bus.done),       0);
    chk({tag, ".pass"},       32'(bus.pass),       0);
    chk({tag, ".err_count"},  32'(bus.err_count),  0);
    chk({tag, ".first_fail"}, 32'(bus.first_fail), 0);
  endtask

  // Call at a negedge while the DUT is idle; returns at a negedge in the cycle after DONE.
  task automatic sweep(input string tag, input logic [3:0] tbl);
    int exp_err = 0;
    int exp_ff  = 0;
    int nvec    = NV;
    for (int i = 0; i < NV; i++)
      if (tbl[i] != TRUTH[i]) begin
        if (exp_err == 0) exp_ff = i;
        exp_err++;
      end
`ifdef TC_SWEEP_STOP_ON_FAIL_EN
    if (exp_err > 0) begin
      nvec    = exp_ff + 1;
      exp_err = 1;
    end
`endif
    gate_tbl  = tbl;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int t = 0; t < nvec * H; t++) begin
      if (t == 0) begin
        chk({tag, ".clr_err"},  32'(bus.err_count),  0);
        chk({tag, ".clr_ff"},   32'(bus.first_fail), 0);
        chk({tag, ".clr_pass"}, 32'(bus.pass),       0);
      end
      if (t % H == 0 || t % H == H - 1) begin
        chk({tag, ".busy"},    32'(bus.busy),    1);
        chk({tag, ".gate_in"}, 32'(bus.gate_in), t / H);
        chk({tag, ".done_lo"}, 32'(bus.done),    0);
      end
      @(negedge clk);
    end
    chk({tag, ".done"},       32'(bus.done),       1);
    chk({tag, ".busy_end"},   32'(bus.busy),       0);
    chk({tag, ".gate_in0"},   32'(bus.gate_in),    0);
    chk({tag, ".err_count"},  32'(bus.err_count),  exp_err);
    chk({tag, ".first_fail"}, 32'(bus.first_fail), exp_ff);
    chk({tag, ".pass"},       32'(bus.pass),       (exp_err == 0) ? 1 : 0);
    @(negedge clk);
    chk({tag, ".done_pulse"}, 32'(bus.done),       0);
    chk({tag, ".pass_held"},  32'(bus.pass),       (exp_err == 0) ? 1 : 0);
  endtask

  initial begin
    int done_cnt;
    int done_at[$];
    logic [3:0] r;
    bus.start = 1'b0;

    // Reset behaviour
    repeat (3) @(negedge clk);
    chk_zero("in_reset");
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_zero("post_reset");
    end

    // Directed gates
    sweep("and_ok",  4'b1000);
    sweep("stuck0",  4'b0000);
    sweep("or_gate", 4'b1110);

    // Random gate tables
    for (int i = 0; i < 6; i++) begin
      r = 4'($urandom_range(0, 15));
      sweep("rand", r);
    end

    // Leave failing results, then hold start: results clear on acceptance
    sweep("pre_hold", 4'b0000);
    gate_tbl  = 4'b1000;
    bus.start = 1'b1;
    done_cnt  = 0;
    for (int i = 0; i <= 260; i++) begin
      @(negedge clk);
      if (i == 0) begin
        chk("hold.clr_err",  32'(bus.err_count),  0);
        chk("hold.clr_ff",   32'(bus.first_fail), 0);
        chk("hold.clr_pass", 32'(bus.pass),       0);
        chk("hold.busy",     32'(bus.busy),       1);
      end
      if (i == 240) bus.start = 1'b0;
      if (bus.done === 1'b1) begin
        done_cnt++;
        done_at.push_back(i);
      end
    end
    chk("hold.done_cnt", 32'(done_cnt), 3);
    if (done_at.size() == 3) begin
      chk("hold.first_done", 32'(done_at[0]), 80);
      chk("hold.period1",    32'(done_at[1] - done_at[0]), 82);
      chk("hold.period2",    32'(done_at[2] - done_at[1]), 82);
    end
    chk("hold.idle_busy", 32'(bus.busy), 0);
    chk("hold.pass",      32'(bus.pass), 1);

    // Reset in the middle of vector 2
    gate_tbl  = 4'b1000;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (49) @(negedge clk);
    chk("mid.busy_before", 32'(bus.busy),    1);
    chk("mid.vec_before",  32'(bus.gate_in), 2);
    rst = 1'b0;
    #1;
    chk_zero("mid_reset");
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 5) rst = 1'b1;
      if (bus.done === 1'b1) done_cnt++;
    end
    chk("mid.no_done", 32'(done_cnt), 0);
    chk_zero("after_mid");
    sweep("after_rst", 4'b1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
